// File: rtl/hazard_aer_serializer.sv
// hazard_aer_serializer
//
// Purpose:
//   Takes one 32-cell hazard occupancy frame over a valid/ready handshake.
//   It then replays that frame to the SNN core as address-event (AER)
//   spikes for NUM_STEPS timesteps. One event goes out per cycle, in
//   ascending cell order, and the consumer can apply backpressure.
//   Each step ends with a single STEP_END cycle. The final STEP_END of
//   a frame also raises frame_done.
//
// Optional feature:
//   `define CHANGE_ONLY_EN enables change-only mode. The block keeps the
//   previous frame and emits only cells whose occupancy changed. ev_pol
//   then marks onset (1) or offset (0). Without the macro, every occupied
//   cell is emitted with polarity 1.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset; all outputs forced low
//   in_valid   in   frame offered
//   in_ready   out  idle and able to accept a frame
//   vec1       in   occupancy of cells 0-15 (bit n = cell n)
//   vec2       in   occupancy of cells 16-31 (bit n = cell n+16)
//   ev_valid   out  event present
//   ev_ready   in   consumer accepts the event
//   ev_addr    out  cell number (row*8+col)
//   ev_pol     out  event polarity, 1 = onset
//   ev_step    out  current timestep index
//   ev_last    out  last event of the current step
//   step_done  out  one-cycle pulse at the end of each step
//   frame_done out  one-cycle pulse on the final step_done of a frame
module hazard_aer_serializer #(
    parameter int NUM_STEPS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] vec1,
    input  logic [15:0] vec2,
    output logic        ev_valid,
    input  logic        ev_ready,
    output logic [4:0]  ev_addr,
    output logic        ev_pol,
    output logic [7:0]  ev_step,
    output logic        ev_last,
    output logic        step_done,
    output logic        frame_done
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_EMIT     = 2'd1;
    localparam logic [1:0] S_STEP_END = 2'd2;

    localparam logic [7:0] LAST_STEP = 8'(NUM_STEPS - 1);

    logic [1:0]  r_state;
    logic [31:0] r_frame;
    logic [31:0] r_pending;
    logic [7:0]  r_step;

    logic [31:0] w_frame_in;
    logic [31:0] w_mask_new;
    logic [31:0] w_mask_stored;
    logic [4:0]  w_low_idx;
    logic [31:0] w_pending_rest;
    logic        w_one_left;

    assign w_frame_in = {vec2, vec1};

`ifdef CHANGE_ONLY_EN
    // The delta is computed once at acceptance and replayed unchanged
    // for every step. It is kept in r_mask because r_prev moves to the
    // new frame on the same edge.
    logic [31:0] r_prev;
    logic [31:0] r_mask;

    assign w_mask_new    = w_frame_in ^ r_prev;
    assign w_mask_stored = r_mask;
`else
    assign w_mask_new    = w_frame_in;
    assign w_mask_stored = r_frame;
`endif

    // Lowest set bit of the pending mask. The scan runs downward so the
    // last hit wins, which gives ascending cell order on the output.
    always_comb begin
        w_low_idx = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_low_idx = 5'(i);
            end
        end
    end

    // x & (x-1) clears the lowest set bit. If the result is zero, the
    // event now on the bus is the last one of this step.
    assign w_pending_rest = r_pending & (r_pending - 32'd1);
    assign w_one_left     = (w_pending_rest == 32'd0);

    // Every output is gated by rst_n so the block looks fully quiet while
    // reset is held, even though the reset itself only acts at an edge.
    always_comb begin
        in_ready   = rst_n && (r_state == S_IDLE);
        ev_valid   = rst_n && (r_state == S_EMIT);
        step_done  = rst_n && (r_state == S_STEP_END);
        frame_done = step_done && (r_step == LAST_STEP);
        ev_step    = rst_n ? r_step : 8'd0;
        ev_addr    = ev_valid ? w_low_idx : 5'd0;
        ev_last    = ev_valid && w_one_left;
`ifdef CHANGE_ONLY_EN
        ev_pol     = ev_valid && r_frame[w_low_idx];
`else
        ev_pol     = ev_valid;
`endif
    end

    // Main sequencer.
    // In IDLE it captures a frame. In EMIT it drains the pending mask one
    // event per accepted handshake. STEP_END always lasts exactly one
    // cycle and either reloads the mask for the next step or returns to
    // IDLE. r_frame is written only at capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_frame   <= 32'd0;
            r_pending <= 32'd0;
            r_step    <= 8'd0;
`ifdef CHANGE_ONLY_EN
            r_prev    <= 32'd0;
            r_mask    <= 32'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_frame   <= w_frame_in;
                        r_pending <= w_mask_new;
                        r_step    <= 8'd0;
`ifdef CHANGE_ONLY_EN
                        r_prev    <= w_frame_in;
                        r_mask    <= w_mask_new;
`endif
                        r_state   <= (w_mask_new != 32'd0) ? S_EMIT : S_STEP_END;
                    end
                end
                S_EMIT: begin
                    if (ev_ready) begin
                        r_pending <= w_pending_rest;
                        if (w_one_left) begin
                            r_state <= S_STEP_END;
                        end
                    end
                end
                S_STEP_END: begin
                    if (r_step == LAST_STEP) begin
                        r_step  <= 8'd0;
                        r_state <= S_IDLE;
                    end else begin
                        r_step    <= r_step + 8'd1;
                        r_pending <= w_mask_stored;
                        r_state   <= (w_mask_stored != 32'd0) ? S_EMIT : S_STEP_END;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_aer_serializer.sv
// tb_hazard_aer_serializer
//
// Directed bench for hazard_aer_serializer with NUM_STEPS = 4. Inputs
// change 1 ns after each rising edge, and outputs are checked at that
// same point. The steps cover these cases:
//   - reset state
//   - a two-cell frame
//   - a frame offered mid-stream that must wait
//   - an empty frame
//   - backpressure on cell 31
//   - reset in the middle of a frame
//   - change-only polarity, when CHANGE_ONLY_EN is defined
module tb_hazard_aer_serializer;

    logic        clk;
    logic        rstN;
    logic        inValid;
    logic        inReady;
    logic [15:0] vec1;
    logic [15:0] vec2;
    logic        evValid;
    logic        evReady;
    logic [4:0]  evAddr;
    logic        evPol;
    logic [7:0]  evStep;
    logic        evLast;
    logic        stepDone;
    logic        frameDone;

    int compared = 0;
    int mismatched = 0;

    hazard_aer_serializer #(.NUM_STEPS(4)) dut (
        .clk        (clk),
        .rst_n      (rstN),
        .in_valid   (inValid),
        .in_ready   (inReady),
        .vec1       (vec1),
        .vec2       (vec2),
        .ev_valid   (evValid),
        .ev_ready   (evReady),
        .ev_addr    (evAddr),
        .ev_pol     (evPol),
        .ev_step    (evStep),
        .ev_last    (evLast),
        .step_done  (stepDone),
        .frame_done (frameDone)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle and land 1 ns past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] a,
                                 input logic [15:0] b, input logic r);
        inValid = v;
        vec1    = a;
        vec2    = b;
        evReady = r;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("[TB] check %s differs", tag);
        end
    endtask

    // Bus snapshot: {inReady, evValid, evAddr, evPol, evLast, evStep, stepDone, frameDone}
    function automatic logic [31:0] bus();
        return {14'd0, inReady, evValid, evAddr, evPol, evLast, evStep, stepDone, frameDone};
    endfunction

    function automatic logic [31:0] expBus(input logic rdy, input logic v,
                                           input logic [4:0] a, input logic p,
                                           input logic l, input logic [7:0] s,
                                           input logic sd, input logic fd);
        return {14'd0, rdy, v, a, p, l, s, sd, fd};
    endfunction

    initial begin
        // Reset: every output is low while rst_n is held low.
        rstN = 1'b0;
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1);
        tick();
        checkOutput("reset_outputs", bus(), 32'd0);
        tick();
        checkOutput("reset_held", bus(), 32'd0);
        rstN = 1'b1;
        #1;
        checkOutput("idle_after_reset", bus(), expBus(1, 0, 0, 0, 0, 0, 0, 0));

        // Frame A: cells 0 and 2. Frame B (cell 8) is offered during A
        // and must wait.
        applyStimulus(1'b1, 16'h0005, 16'h0000, 1'b1);
        tick();
        applyStimulus(1'b1, 16'h0100, 16'h0000, 1'b1);
        for (int s = 0; s < 4; s++) begin
            checkOutput($sformatf("a_s%0d_ev0", s), bus(), expBus(0, 1, 5'd0, 1, 0, 8'(s), 0, 0));
            tick();
            checkOutput($sformatf("a_s%0d_ev2", s), bus(), expBus(0, 1, 5'd2, 1, 1, 8'(s), 0, 0));
            tick();
            checkOutput($sformatf("a_s%0d_end", s), bus(), expBus(0, 0, 0, 0, 0, 8'(s), 1, s == 3));
            tick();
        end
        // Cycle 13: idle again, and frame B is still offered.
        checkOutput("a_ready_after", bus(), expBus(1, 0, 0, 0, 0, 0, 0, 0));
        tick();
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1);
        for (int s = 0; s < 4; s++) begin
            checkOutput($sformatf("b_s%0d_ev8", s), bus(), expBus(0, 1, 5'd8, 1, 1, 8'(s), 0, 0));
            tick();
            checkOutput($sformatf("b_s%0d_end", s), bus(), expBus(0, 0, 0, 0, 0, 8'(s), 1, s == 3));
            tick();
        end
        checkOutput("b_ready_after", bus(), expBus(1, 0, 0, 0, 0, 0, 0, 0));

        // Empty frame: four STEP_END cycles in a row, with no events.
        applyStimulus(1'b1, 16'h0000, 16'h0000, 1'b1);
        tick();
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1);
        for (int s = 0; s < 4; s++) begin
            checkOutput($sformatf("empty_s%0d", s), bus(), expBus(0, 0, 0, 0, 0, 8'(s), 1, s == 3));
            tick();
        end
        checkOutput("empty_ready_after", bus(), expBus(1, 0, 0, 0, 0, 0, 0, 0));

        // Cell 31 with ev_ready low for 3 cycles.
        applyStimulus(1'b1, 16'h0000, 16'h8000, 1'b0);
        tick();
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0);
        for (int j = 0; j < 3; j++) begin
            checkOutput($sformatf("bp_hold%0d", j), bus(), expBus(0, 1, 5'd31, 1, 1, 0, 0, 0));
            tick();
        end
        evReady = 1'b1;
        #1;
        for (int s = 0; s < 4; s++) begin
            checkOutput($sformatf("bp_s%0d_ev31", s), bus(), expBus(0, 1, 5'd31, 1, 1, 8'(s), 0, 0));
            tick();
            checkOutput($sformatf("bp_s%0d_end", s), bus(), expBus(0, 0, 0, 0, 0, 8'(s), 1, s == 3));
            tick();
        end
        checkOutput("bp_ready_after", bus(), expBus(1, 0, 0, 0, 0, 0, 0, 0));

        // All 16 low cells set. Step 0 takes 17 cycles, so cycle 18 is
        // step 1, cell 0.
        applyStimulus(1'b1, 16'hFFFF, 16'h0000, 1'b1);
        tick();
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1);
        for (int j = 0; j < 17; j++) tick();
        checkOutput("full_s1_ev0", bus(), expBus(0, 1, 5'd0, 1, 0, 8'd1, 0, 0));
        tick();
        tick();
        checkOutput("full_s1_ev2", bus(), expBus(0, 1, 5'd2, 1, 0, 8'd1, 0, 0));
        rstN = 1'b0;
        #1;
        checkOutput("midreset_low", bus(), 32'd0);
        tick();
        checkOutput("midreset_edge", bus(), 32'd0);
        rstN = 1'b1;
        #1;
        checkOutput("midreset_idle", bus(), expBus(1, 0, 0, 0, 0, 0, 0, 0));
        for (int j = 0; j < 20; j++) begin
            tick();
            checkOutput($sformatf("midreset_quiet%0d", j), bus(), expBus(1, 0, 0, 0, 0, 0, 0, 0));
        end

`ifdef CHANGE_ONLY_EN
        // prev is 0 after reset. {1,3} gives onsets at 1 and 3. Then
        // {3,4} gives an offset at 1 and an onset at 4.
        applyStimulus(1'b1, 16'h000A, 16'h0000, 1'b1);
        tick();
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1);
        for (int s = 0; s < 4; s++) begin
            checkOutput($sformatf("co1_s%0d_ev1", s), bus(), expBus(0, 1, 5'd1, 1, 0, 8'(s), 0, 0));
            tick();
            checkOutput($sformatf("co1_s%0d_ev3", s), bus(), expBus(0, 1, 5'd3, 1, 1, 8'(s), 0, 0));
            tick();
            tick();
        end
        applyStimulus(1'b1, 16'h0018, 16'h0000, 1'b1);
        tick();
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1);
        for (int s = 0; s < 4; s++) begin
            checkOutput($sformatf("co2_s%0d_ev1", s), bus(), expBus(0, 1, 5'd1, 0, 0, 8'(s), 0, 0));
            tick();
            checkOutput($sformatf("co2_s%0d_ev4", s), bus(), expBus(0, 1, 5'd4, 1, 1, 8'(s), 0, 0));
            tick();
            checkOutput($sformatf("co2_s%0d_end", s), bus(), expBus(0, 0, 0, 0, 0, 8'(s), 1, s == 3));
            tick();
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/hazard_aer_serializer.md
# hazard_aer_serializer

Downstream neighbour of the hazard grid encoder. It accepts one 32-cell hazard occupancy frame (two 16-bit halves) through a valid/ready handshake. It replays that frame as a stream of address-event (AER) spikes for NUM_STEPS SNN timesteps, one event per cycle, with backpressure. The SNN core consumes the events directly.

## Interface
- NUM_STEPS, 4: timesteps per frame; legal range 1–256.
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- in_valid  in  1  frame offered.
- in_ready  out  1  block idle and able to accept a frame.
- vec1  in  16  occupancy of cells 0–15; bit n = cell n.
- vec2  in  16  occupancy of cells 16–31; bit n = cell n+16.
- ev_valid  out  1  event present.
- ev_ready  in  1  consumer accepts the event.
- ev_addr  out  5  cell number, row*8+col.
- ev_pol  out  1  event polarity; 1 = onset.
- ev_step  out  8  current timestep index, 0..NUM_STEPS-1.
- ev_last  out  1  this event is the last one of the current step.
- step_done  out  1  one-cycle pulse marking the end of a step.
- frame_done  out  1  one-cycle pulse on the final step_done of a frame.

## Operation
- Internal registers: frame (32 b), pending mask (32 b), step counter (8 b), state.
- Frame register layout: {vec2, vec1}.
- State IDLE:
  - in_ready = 1.
  - On in_valid && in_ready, capture the frame and set step = 0.
  - Load pending with the event mask (see Configuration).
  - Next state is EMIT if pending != 0, otherwise STEP_END.
- State EMIT:
  - ev_valid = 1.
  - ev_addr = index of the lowest set bit of pending, so events go out in ascending cell order.
  - ev_last = 1 when pending has exactly one bit set.
  - On ev_valid && ev_ready, clear that bit. If it was the last bit, go to STEP_END.
- State STEP_END: lasts exactly one cycle, with step_done = 1.
  - If step == NUM_STEPS-1: frame_done = 1, next state IDLE.
  - Otherwise: step increments, pending reloads from the stored event mask, next state is EMIT or STEP_END as in IDLE.
- in_ready = 0 outside IDLE. in_valid there is ignored and not latched.
- ev_addr, ev_pol, ev_last and ev_step hold stable while ev_valid && !ev_ready.
- When ev_valid = 0, ev_addr, ev_pol and ev_last are 0.
- The frame register does not change between capture and return to IDLE.

## Timing
- Reset (rst_n = 0 at a clk edge):
  - state → IDLE; all registers → 0.
  - All outputs are 0 while rst_n = 0, including in_ready, which is forced low.
  - in_ready = 1 from the first cycle after rst_n returns high.
- Reset mid-frame: the frame is abandoned, no further events or pulses, and the previous-frame register is also cleared.
- Latency: first ev_valid appears the cycle after the capture edge.
- With ev_ready held high and K set cells:
  - Each step takes K+1 cycles (K events, then STEP_END).
  - A frame takes NUM_STEPS*(K+1) cycles.
  - in_ready is high in the cycle after the frame_done cycle.
- Empty frame (K = 0): NUM_STEPS consecutive STEP_END cycles with no ev_valid.
- Backpressure stalls only EMIT. STEP_END never waits on ev_ready.
- ev_step equals the step counter in both EMIT and STEP_END.

## Configuration
- CHANGE_ONLY_EN defined:
  - Adds a 32-bit previous-frame register, reset to 0.
  - Event mask = frame XOR prev, captured at frame acceptance; prev ← new frame on the same edge.
  - ev_pol = frame bit at ev_addr: 1 for onset, 0 for offset.
  - The same delta is replayed for every step.
- CHANGE_ONLY_EN undefined:
  - No previous-frame register.
  - Event mask = frame.
  - ev_pol is constant 1 whenever ev_valid = 1.

## Test plan
- vec1 = 16'h0005, vec2 = 0, NUM_STEPS = 4, ev_ready = 1 → per step: addr 0, then addr 2 with ev_last, then step_done. ev_step runs 0..3. frame_done in cycle 12 after capture. in_ready in cycle 13.
- vec1 = vec2 = 0 → four step_done pulses in cycles 1–4, frame_done in cycle 4, ev_valid never asserted.
- vec2 = 16'h8000 with ev_ready low for 3 cycles → ev_valid = 1 and ev_addr = 31 held all 3 cycles. Exactly one event is accepted per step.
- New in_valid with different data mid-frame → in_ready = 0 and the data is ignored. It is accepted the cycle after frame_done, and events match the new data.
- rst_n low for 1 cycle during step 1 of vec1 = 16'hFFFF → all outputs 0 next cycle. Idle with in_ready = 1 after release. No stray pulses.
- CHANGE_ONLY_EN: frame {cells 1, 3}, then frame {cells 3, 4} → second frame emits addr 1 with pol 0, then addr 4 with pol 1, each step. First frame emits addr 1 and 3 with pol 1.
